hrtf_angle_slew: RTL and testbench

Conditions the user-controlled source angle before it reaches the HRTF address generator. Raw switch/joystick angle is synchronised, range-checked and debounced in units of audio frames. The output then moves toward the debounced target one index at a time, along the shortest circular path, at a bounded rate. The output updates only on `new_sample` edges, so each convolution frame uses a single coefficient set, and large jumps are spread over several steps so that switching HRTFs does not produce an audible click.

---
 rtl/hrtf_angle_slew.sv | 173 +++++++++++++++++
 tb/tb_hrtf_angle_slew.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hrtf_angle_slew.sv
// hrtf_angle_slew
//
// Conditions the user-controlled source angle before it reaches the HRTF
// address generator. The raw angle is synchronised, range-checked and
// debounced in units of audio frames. The output then walks toward the
// debounced target one index at a time, along the shortest circular path,
// with one step every STEP_SAMPLES frames. All state advances only on
// new_sample, so each convolution frame sees a single coefficient set.
//
// Parameters:
//   NUM_ANGLES       number of valid angle indices (0..NUM_ANGLES-1), 2..256
//   DEBOUNCE_SAMPLES consecutive frames a raw value must hold to become target, >= 1
//   STEP_SAMPLES     frames between successive one-index output steps, >= 1
//   RESET_ANGLE      output, target and candidate value after reset, < NUM_ANGLES
//
// Ports:
//   clk          audio clock (same domain as the I2S controller)
//   reset_n      synchronous active-low reset
//   raw_angle    asynchronous angle from switches / joystick
//   new_sample   one-cycle frame pulse
//   angle_out    registered angle index for the address generator
//   target_angle current debounced target
//   moving       registered, high while angle_out != target_angle

module hrtf_angle_slew #(
    parameter int unsigned NUM_ANGLES       = 72,
    parameter int unsigned DEBOUNCE_SAMPLES = 480,
    parameter int unsigned STEP_SAMPLES     = 96,
    parameter int unsigned RESET_ANGLE      = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] raw_angle,
    input  logic       new_sample,
    output logic [7:0] angle_out,
    output logic [7:0] target_angle,
    output logic       moving
);

    // Modular arithmetic runs in 9 bits so NUM_ANGLES = 256 cannot overflow.
    localparam logic [8:0] NUM9      = 9'(NUM_ANGLES);
    localparam logic [8:0] HALF9     = 9'(NUM_ANGLES / 2);
    localparam logic [7:0] TOP_ANGLE = 8'(NUM_ANGLES - 1);
    localparam logic [7:0] RESET_VAL = 8'(RESET_ANGLE);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SAMPLES);
    localparam logic [DEB_W-1:0] DEB_PRE = DEB_W'(DEBOUNCE_SAMPLES - 1);

    localparam int unsigned STEP_W = $clog2(STEP_SAMPLES + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_SAMPLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSlew
    } slew_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        sync_meta;
    logic [7:0]        sync_angle;
    logic [7:0]        cand;
    logic [DEB_W-1:0]  stable_cnt;
    logic [STEP_W-1:0] step_cnt;
    slew_state_e       state;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       sync_valid;
    logic [7:0] target_next;
    logic [8:0] diff_raw;
    logic [8:0] diff;
    logic       step_up;
    logic [7:0] angle_inc;
    logic [7:0] angle_dec;
    logic [7:0] angle_step;

    assign sync_valid = ({1'b0, sync_angle} < NUM9);

    // Target as it will be after this edge. The slew logic looks at this
    // value so that a target update and the slew reaction land on the same
    // frame pulse, which keeps back-to-back pulses from being lost.
    always_comb begin
        target_next = target_angle;
        if (new_sample && sync_valid && (sync_angle == cand) && (stable_cnt == DEB_PRE)) begin
            target_next = cand;
        end
    end

    // Shortest-path direction: d = (target - out) mod N, step up when
    // 1 <= d <= floor(N/2); the even-N tie therefore steps up.
    always_comb begin
        diff_raw = {1'b0, target_next} + NUM9 - {1'b0, angle_out};
        diff     = (diff_raw >= NUM9) ? (diff_raw - NUM9) : diff_raw;
        step_up  = (diff != 9'd0) && (diff <= HALF9);
    end

    always_comb begin
        angle_inc  = (angle_out == TOP_ANGLE) ? 8'd0 : (angle_out + 8'd1);
        angle_dec  = (angle_out == 8'd0) ? TOP_ANGLE : (angle_out - 8'd1);
        angle_step = step_up ? angle_inc : angle_dec;
    end

    // ------------------------------------------------------------------
    // Synchroniser, debouncer and slew FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta    <= 8'd0;
            sync_angle   <= 8'd0;
            cand         <= RESET_VAL;
            stable_cnt   <= '0;
            target_angle <= RESET_VAL;
            angle_out    <= RESET_VAL;
            step_cnt     <= '0;
            moving       <= 1'b0;
            state        <= StIdle;
        end else begin
            sync_meta  <= raw_angle;
            sync_angle <= sync_meta;

            // Debounce, evaluated once per frame.
            if (new_sample) begin
                if (!sync_valid) begin
                    stable_cnt <= '0;
                end else if (sync_angle != cand) begin
                    cand       <= sync_angle;
                    stable_cnt <= '0;
                end else if (stable_cnt != DEB_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                target_angle <= target_next;
            end

            unique case (state)
                StIdle: begin
                    if (target_next != angle_out) begin
                        state    <= StSlew;
                        step_cnt <= '0;
                        moving   <= 1'b1;
                    end
                end
                StSlew: begin
                    if (new_sample) begin
                        if (target_next == angle_out) begin
                            // Retargeted onto the current output: stop here.
                            state    <= StIdle;
                            step_cnt <= '0;
                            moving   <= 1'b0;
                        end else if (step_cnt == STEP_LAST) begin
                            angle_out <= angle_step;
                            step_cnt  <= '0;
                            if (angle_step == target_next) begin
                                state  <= StIdle;
                                moving <= 1'b0;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    step_cnt <= '0;
                    moving   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hrtf_angle_slew.sv
// Testbench for hrtf_angle_slew: directed scenarios plus a randomized phase,
// every cycle compared against a frame-level behavioural model.

module tb_hrtf_angle_slew;

    localparam int N    = 8;
    localparam int DEB  = 3;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] raw_angle = 8'd0;
    logic       new_sample = 1'b0;
    logic [7:0] angle_out;
    logic [7:0] target_angle;
    logic       moving;

    always #5 clk = ~clk;

    hrtf_angle_slew #(
        .NUM_ANGLES      (N),
        .DEBOUNCE_SAMPLES(DEB),
        .STEP_SAMPLES    (STEP),
        .RESET_ANGLE     (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw_angle   (raw_angle),
        .new_sample  (new_sample),
        .angle_out   (angle_out),
        .target_angle(target_angle),
        .moving      (moving)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_s1, m_s2, m_cand, m_cnt, m_tgt, m_out, m_phase;
    bit m_slew;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the behaviour: two-stage sync delay, debounce per
    // frame, then a frame counter that moves the output one index each
    // STEP frames along the shorter way round the circle.
    task automatic model_step(input int raw, input bit ns, input bit rst);
        int sync_v;
        int d;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_cand = 0; m_cnt = 0;
            m_tgt = 0; m_out = 0; m_phase = 0; m_slew = 0;
        end else begin
            sync_v = m_s2;
            m_s2   = m_s1;
            m_s1   = raw;
            if (ns) begin
                if (sync_v >= N) m_cnt = 0;
                else if (sync_v != m_cand) begin
                    m_cand = sync_v;
                    m_cnt  = 0;
                end else if (m_cnt < DEB) begin
                    m_cnt++;
                    if (m_cnt == DEB) m_tgt = m_cand;
                end
            end
            if (!m_slew) begin
                if (m_tgt != m_out) begin
                    m_slew  = 1;
                    m_phase = 0;
                end
            end else if (ns) begin
                if (m_tgt == m_out) m_slew = 0;
                else begin
                    m_phase++;
                    if (m_phase == STEP) begin
                        m_phase = 0;
                        d = (m_tgt - m_out + N) % N;
                        if (d <= N / 2) m_out = (m_out + 1) % N;
                        else m_out = (m_out + N - 1) % N;
                        if (m_out == m_tgt) m_slew = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick(input int raw, input bit ns, input bit rst);
        @(negedge clk);
        raw_angle  = 8'(raw);
        new_sample = ns;
        reset_n    = rst;
        @(posedge clk);
        model_step(raw, ns, rst);
        #1;
        check("angle_out", int'(angle_out), m_out);
        check("target_angle", int'(target_angle), m_tgt);
        check("moving", int'(moving), int'(m_out != m_tgt));
    endtask

    // Let raw reach sync_angle, then apply the four frames that commit it.
    task automatic go_target(input int raw);
        tick(raw, 0, 1);
        tick(raw, 0, 1);
        repeat (DEB + 1) tick(raw, 1, 1);
        check("go_target", int'(target_angle), raw);
    endtask

    // Back-to-back frame pairs; each pair should produce exactly one step.
    task automatic walk(input string tag, input int raw, input int path[$]);
        foreach (path[i]) begin
            tick(raw, 1, 1);
            tick(raw, 1, 1);
            check(tag, int'(angle_out), path[i]);
        end
    endtask

    int path[$];
    int raw_cur;

    initial begin
        // 1. Reset with activity on the inputs.
        repeat (4) tick(5, 1, 0);
        check("rst_out", int'(angle_out), 0);
        check("rst_tgt", int'(target_angle), 0);
        check("rst_moving", int'(moving), 0);

        // 2. Debounce timing and glitch restart.
        repeat (3) tick(2, 0, 1);
        repeat (3) tick(2, 1, 1);
        check("deb_early", int'(target_angle), 0);
        tick(2, 1, 1);
        check("deb_hit", int'(target_angle), 2);
        repeat (10) tick(2, 1, 1);
        check("deb_settle", int'(angle_out), 2);
        tick(3, 0, 1);
        tick(3, 0, 1);
        tick(3, 1, 1);
        tick(5, 0, 1);
        tick(5, 0, 1);
        tick(5, 1, 1);
        tick(3, 0, 1);
        tick(3, 0, 1);
        tick(3, 1, 1);
        tick(3, 1, 1);
        check("glitch_hold", int'(target_angle), 2);
        tick(3, 1, 1);
        tick(3, 1, 1);
        check("glitch_commit", int'(target_angle), 3);
        repeat (10) tick(3, 1, 1);

        // 3. Slew up from reset.
        tick(0, 0, 0);
        go_target(3);
        check("slew_start", int'(moving), 1);
        path = '{1, 2, 3};
        walk("slew_up", 3, path);
        check("slew_up_done", int'(moving), 0);

        // 4. Shortest path with wrap, including the even-N tie.
        go_target(1);
        path = '{2, 1};
        walk("slew_down", 1, path);
        go_target(6);
        path = '{0, 7, 6};
        walk("wrap_down", 6, path);
        go_target(2);
        path = '{7, 0, 1, 2};
        walk("wrap_tie", 2, path);
        check("wrap_done", int'(moving), 0);

        // 5. Out-of-range inputs.
        repeat (10) tick(9, 1, 1);
        check("inv9_tgt", int'(target_angle), 2);
        check("inv9_cnt", int'(dut.stable_cnt), 0);
        repeat (10) tick(200, 1, 1);
        check("inv200_tgt", int'(target_angle), 2);
        check("inv200_cnt", int'(dut.stable_cnt), 0);
        go_target(4);
        path = '{3, 4};
        walk("inv_recover", 4, path);

        // Reset mid-slew.
        go_target(1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        check("mid_rst_pre", int'(moving), 1);
        tick(1, 1, 0);
        check("mid_rst_out", int'(angle_out), 0);
        check("mid_rst_tgt", int'(target_angle), 0);
        check("mid_rst_moving", int'(moving), 0);

        // 6. Retarget mid-slew keeps the step cadence.
        go_target(4);
        tick(4, 1, 1);
        tick(7, 0, 1);
        tick(7, 0, 1);
        tick(7, 1, 1);
        check("retgt_at1", int'(angle_out), 1);
        tick(7, 1, 1);
        tick(7, 1, 1);
        check("retgt_at2", int'(angle_out), 2);
        tick(7, 1, 1);
        check("retgt_tgt", int'(target_angle), 7);
        path = '{1, 0, 7};
        walk("retgt_path", 7, path);
        check("retgt_done", int'(moving), 0);

        // Randomized phase: held values, glitches, invalid codes, sparse and
        // back-to-back pulses, occasional reset.
        raw_cur = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 5) == 0) raw_cur = $urandom_range(N, 255);
                else raw_cur = $urandom_range(0, N - 1);
            end
            tick(raw_cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 599) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
